// File: rtl/wm_pkg.sv
// Shared encodings and thresholds for the washing-machine controller and its timer.
package wm_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'b000,
      ST_FILL  = 3'b001,
      ST_WASH  = 3'b011,
      ST_RINSE = 3'b010,
      ST_SPIN  = 3'b110,
      ST_PAUSE = 3'b111
   } wm_state_e;

   typedef enum logic [1:0] {
      FREQ_1X = 2'b00,
      FREQ_2X = 2'b01,
      FREQ_4X = 2'b10,
      FREQ_8X = 2'b11
   } wm_freq_e;

   localparam logic [2:0] ONE_MIN      = 3'd1;
   localparam logic [2:0] TWO_MIN      = 3'd2;
   localparam logic [2:0] FIVE_MIN     = 3'd5;
   localparam logic [2:0] MAX_MIN      = 3'd7;
   localparam int         SECS_PER_MIN = 60;
   localparam logic [1:0] WASH_SAT     = 2'b11;

endpackage

// File: rtl/wm_timer_if.sv
// Controller <-> timer signal bundle; the controller drives strobes, the timer answers with flags.
interface wm_timer_if;

   logic [1:0] WM_TIMER_clk_freq;
   logic       WM_TIMER_cnt_en;
   logic       WM_TIMER_cnt_done;
   logic [2:0] WM_TIMER_state;
   logic       WM_TIMER_one_min;
   logic       WM_TIMER_two_min;
   logic       WM_TIMER_five_min;
   logic [1:0] WM_TIMER_wash_count;

   modport master (
      output WM_TIMER_clk_freq, WM_TIMER_cnt_en, WM_TIMER_cnt_done, WM_TIMER_state,
      input  WM_TIMER_one_min, WM_TIMER_two_min, WM_TIMER_five_min, WM_TIMER_wash_count
   );

   modport slave (
      input  WM_TIMER_clk_freq, WM_TIMER_cnt_en, WM_TIMER_cnt_done, WM_TIMER_state,
      output WM_TIMER_one_min, WM_TIMER_two_min, WM_TIMER_five_min, WM_TIMER_wash_count
   );

endinterface

// File: rtl/wm_prescaler.sv
// Divides the machine clock down to a one-second strobe whose period tracks the selected clock rate.
module wm_prescaler #(
   parameter int CYCLES_PER_SEC_BASE = 1000000,
   parameter int TICK_W              = 23
) (
   input  logic       WMFSM_CLK,
   input  logic       WMFSM_RST,
   input  logic       en,
   input  logic       clr,
   input  logic [1:0] clk_freq,
   output logic       sec_tick
);

   localparam logic [TICK_W-1:0] BASE = TICK_W'(CYCLES_PER_SEC_BASE);

   logic [TICK_W-1:0] tick;
   logic [TICK_W-1:0] tc;
   logic              at_tc;

   // >= rather than == so a rate drop mid-second fires on the next enabled edge instead of wrapping.
   assign tc       = (BASE << clk_freq) - TICK_W'(1);
   assign at_tc    = (tick >= tc);
   assign sec_tick = en & ~clr & at_tc;

   always_ff @(posedge WMFSM_CLK or posedge WMFSM_RST) begin
      if (WMFSM_RST) begin
         tick <= '0;
      end else if (clr) begin
         tick <= '0;
      end else if (en) begin
         if (at_tc) begin
            tick <= '0;
         end else begin
            tick <= tick + TICK_W'(1);
         end
      end
   end

endmodule

// File: rtl/wm_timer.sv
// Phase timer for the washing-machine controller: minute flags and a count of finished wash phases.
module wm_timer
   import wm_pkg::*;
#(
   parameter int CYCLES_PER_SEC_BASE = 1000000,
   parameter int TICK_W              = 23
) (
   input  logic        WM_TIMER_CLK,
   input  logic        WM_TIMER_RST,
   wm_timer_if.slave   bus
);

   logic       sec_tick;
   logic [5:0] seconds;
   logic [2:0] minutes;
   logic [1:0] wash_count;

   wm_prescaler #(
      .CYCLES_PER_SEC_BASE (CYCLES_PER_SEC_BASE),
      .TICK_W              (TICK_W)
   ) u_prescaler (
      .WMFSM_CLK (WM_TIMER_CLK),
      .WMFSM_RST (WM_TIMER_RST),
      .en        (bus.WM_TIMER_cnt_en),
      .clr       (bus.WM_TIMER_cnt_done),
      .clk_freq  (bus.WM_TIMER_clk_freq),
      .sec_tick  (sec_tick)
   );

   // Minutes saturate rather than wrap so a stalled phase never looks like a fresh one.
   always_ff @(posedge WM_TIMER_CLK or posedge WM_TIMER_RST) begin
      if (WM_TIMER_RST) begin
         seconds <= '0;
         minutes <= '0;
      end else if (bus.WM_TIMER_cnt_done) begin
         seconds <= '0;
         minutes <= '0;
      end else if (sec_tick) begin
         if (seconds == 6'(SECS_PER_MIN - 1)) begin
            seconds <= '0;
            if (minutes != MAX_MIN) begin
               minutes <= minutes + 3'd1;
            end
         end else begin
            seconds <= seconds + 6'd1;
         end
      end
   end

   always_ff @(posedge WM_TIMER_CLK or posedge WM_TIMER_RST) begin
      if (WM_TIMER_RST) begin
         wash_count <= '0;
      end else if (bus.WM_TIMER_state == ST_IDLE) begin
         wash_count <= '0;
      end else if ((bus.WM_TIMER_state == ST_WASH) && bus.WM_TIMER_cnt_done
                   && (wash_count != WASH_SAT)) begin
         wash_count <= wash_count + 2'd1;
      end
   end

   assign bus.WM_TIMER_one_min    = (minutes == ONE_MIN);
   assign bus.WM_TIMER_two_min    = (minutes == TWO_MIN);
   assign bus.WM_TIMER_five_min   = (minutes == FIVE_MIN);
   assign bus.WM_TIMER_wash_count = wash_count;

endmodule

// File: tb/tb_wm_timer.sv
// Self-checking bench for wm_timer: directed timing scenarios plus randomized traffic against an elapsed-time model.
module tb_wm_timer;

   localparam int CPS = 4;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   wm_timer_if bus_if ();

   wm_timer #(
      .CYCLES_PER_SEC_BASE (CPS),
      .TICK_W              (8)
   ) dut (
      .WM_TIMER_CLK (clk),
      .WM_TIMER_RST (rst),
      .bus          (bus_if.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference: edges spent in the current second, total whole seconds since clear, finished washes.
   int m_edges;
   int m_secs;
   int m_wash;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_edges = 0;
         m_secs  = 0;
         m_wash  = 0;
      end else begin
         if (bus_if.WM_TIMER_cnt_done) begin
            m_edges = 0;
            m_secs  = 0;
         end else if (bus_if.WM_TIMER_cnt_en) begin
            m_edges = m_edges + 1;
            if (m_edges >= (CPS << bus_if.WM_TIMER_clk_freq)) begin
               m_edges = 0;
               m_secs  = m_secs + 1;
            end
         end
         if (bus_if.WM_TIMER_state == 3'b000) begin
            m_wash = 0;
         end else if (bus_if.WM_TIMER_state == 3'b011 && bus_if.WM_TIMER_cnt_done) begin
            m_wash = (m_wash < 3) ? m_wash + 1 : 3;
         end
      end
   end

   function automatic int expMinutes();
      return (m_secs / 60 > 7) ? 7 : m_secs / 60;
   endfunction

   task automatic checkOutput(input string name, input int act, input int exp);
      checks = checks + 1;
      if (act != exp) begin
         failures = failures + 1;
         $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      checkOutput("model_one_min", int'(bus_if.WM_TIMER_one_min), int'(expMinutes() == 1));
      checkOutput("model_two_min", int'(bus_if.WM_TIMER_two_min), int'(expMinutes() == 2));
      checkOutput("model_five_min", int'(bus_if.WM_TIMER_five_min), int'(expMinutes() == 5));
      checkOutput("model_wash_count", int'(bus_if.WM_TIMER_wash_count), m_wash);
   end

   logic [2:0] cur_state;
   logic [1:0] cur_freq;

   task automatic applyStimulus(input logic en, input logic done, input logic [2:0] st,
                                input logic [1:0] freq);
      bus_if.WM_TIMER_cnt_en    = en;
      bus_if.WM_TIMER_cnt_done  = done;
      bus_if.WM_TIMER_state     = st;
      bus_if.WM_TIMER_clk_freq  = freq;
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic logic getFlag(input int which);
      case (which)
         0:       return bus_if.WM_TIMER_one_min;
         1:       return bus_if.WM_TIMER_two_min;
         default: return bus_if.WM_TIMER_five_min;
      endcase
   endfunction

   task automatic runUntil(input int which, input int limit, output int edges);
      edges = 0;
      while (edges < limit) begin
         applyStimulus(1'b1, 1'b0, cur_state, cur_freq);
         edges = edges + 1;
         if (getFlag(which)) break;
      end
   endtask

   task automatic runEdges(input logic en, input int n);
      for (int i = 0; i < n; i++) applyStimulus(en, 1'b0, cur_state, cur_freq);
   endtask

   int n;

   initial begin
      checks    = 0;
      failures  = 0;
      cur_state = 3'b001;
      cur_freq  = 2'b00;
      rst       = 1'b1;
      bus_if.WM_TIMER_cnt_en   = 1'b0;
      bus_if.WM_TIMER_cnt_done = 1'b0;
      bus_if.WM_TIMER_state    = cur_state;
      bus_if.WM_TIMER_clk_freq = cur_freq;
      repeat (2) @(negedge clk);
      checkOutput("reset_one_min", int'(bus_if.WM_TIMER_one_min), 0);
      checkOutput("reset_five_min", int'(bus_if.WM_TIMER_five_min), 0);
      checkOutput("reset_wash_count", int'(bus_if.WM_TIMER_wash_count), 0);
      rst = 1'b0;

      // 1x rate: minute flags at 240/480/1200 edges, saturation (no wrap) by edge 2400.
      applyStimulus(1'b0, 1'b1, cur_state, cur_freq);
      runUntil(0, 300, n);
      checkOutput("edges_to_one_min_1x", n, 240);
      runUntil(1, 300, n);
      checkOutput("edges_one_to_two_min", n, 240);
      runUntil(2, 800, n);
      checkOutput("edges_two_to_five_min", n, 720);
      runEdges(1'b1, 1200);
      checkOutput("sat_one_min_low", int'(bus_if.WM_TIMER_one_min), 0);
      checkOutput("sat_two_min_low", int'(bus_if.WM_TIMER_two_min), 0);

      // 8x rate, then clear on the same edge the flag is high with cnt_en still set.
      cur_freq = 2'b11;
      applyStimulus(1'b1, 1'b1, cur_state, cur_freq);
      runUntil(0, 2100, n);
      checkOutput("edges_to_one_min_8x", n, 1920);
      applyStimulus(1'b1, 1'b1, cur_state, cur_freq);
      checkOutput("clear_drops_one_min", int'(bus_if.WM_TIMER_one_min), 0);

      // 8x for 20 edges then drop to 1x: first second on the next edge, then every 4.
      applyStimulus(1'b0, 1'b1, cur_state, cur_freq);
      runEdges(1'b1, 20);
      cur_freq = 2'b00;
      runUntil(0, 300, n);
      checkOutput("edges_after_rate_drop", n, 237);

      // Pause holds the partial count exactly.
      applyStimulus(1'b0, 1'b1, cur_state, cur_freq);
      runEdges(1'b1, 100);
      runEdges(1'b0, 50);
      runUntil(0, 300, n);
      checkOutput("edges_after_pause", n, 140);

      // Wash counting, idle clear, saturation.
      cur_state = 3'b011;
      applyStimulus(1'b1, 1'b1, cur_state, cur_freq);
      checkOutput("wash_first", int'(bus_if.WM_TIMER_wash_count), 1);
      applyStimulus(1'b1, 1'b1, cur_state, cur_freq);
      checkOutput("wash_second", int'(bus_if.WM_TIMER_wash_count), 2);
      applyStimulus(1'b0, 1'b0, 3'b000, cur_freq);
      checkOutput("wash_idle_clear", int'(bus_if.WM_TIMER_wash_count), 0);
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, cur_state, cur_freq);
      checkOutput("wash_third", int'(bus_if.WM_TIMER_wash_count), 3);
      applyStimulus(1'b1, 1'b1, cur_state, cur_freq);
      checkOutput("wash_saturate", int'(bus_if.WM_TIMER_wash_count), 3);

      // Asynchronous reset mid-phase at minute 3 with one wash recorded.
      applyStimulus(1'b0, 1'b0, 3'b000, cur_freq);
      applyStimulus(1'b0, 1'b1, 3'b011, cur_freq);
      cur_state = 3'b001;
      runEdges(1'b1, 760);
      checkOutput("pre_reset_wash", int'(bus_if.WM_TIMER_wash_count), 1);
      #2 rst = 1'b1;
      #1;
      checkOutput("async_reset_wash", int'(bus_if.WM_TIMER_wash_count), 0);
      checkOutput("async_reset_one_min", int'(bus_if.WM_TIMER_one_min), 0);
      @(negedge clk);
      rst = 1'b0;
      runUntil(0, 300, n);
      checkOutput("edges_to_one_min_after_reset", n, 240);

      // Randomized traffic, checked every cycle by the model.
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 199) == 0) cur_freq = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 49) == 0)  cur_state = 3'($urandom_range(0, 7));
         applyStimulus($urandom_range(0, 9) != 0, $urandom_range(0, 399) == 0,
                       cur_state, cur_freq);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
